// File: rtl/octave_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : octave_select_ctrl
//  Description : Debounces the raw octave-up / octave-down pushbuttons and
//                turns them into single-cycle 2-bit select pulses for the
//                octave register stage (01 = up, 10 = down, 00 = idle).
//                Holding one button can auto-repeat the pulse. Simultaneous
//                or overlapping presses are locked out until both buttons
//                are released.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    btn_up     in   raw octave-up button (async, bouncy, active-high)
//    btn_down   in   raw octave-down button (async, bouncy, active-high)
//    select     out  [1:0] registered command pulse: 00 idle, 01 up, 10 down
//    up_level   out  registered debounced level of btn_up
//    down_level out  registered debounced level of btn_down
// ============================================================================
module octave_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 50000000,
   parameter int REPEAT_EN       = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [1:0] select,
   output logic       up_level,
   output logic       down_level
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int RP_W = $clog2(REPEAT_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

   localparam logic [1:0] SEL_IDLE = 2'b00;
   localparam logic [1:0] SEL_UP   = 2'b01;
   localparam logic [1:0] SEL_DOWN = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_UP   = 2'd1,
      HOLD_DOWN = 2'd2,
      LOCKOUT   = 2'd3
   } state_t;

   // bit 0 = up button, bit 1 = down button
   logic [1:0] raw;
   logic [1:0] level;
   logic [1:0] level_d;

   assign raw = {btn_down, btn_up};

   // ------------------------------------------------------------------------
   // Per-button synchronizer and debouncer. The level only follows the
   // synchronized input after DEBOUNCE_CYCLES consecutive disagreeing
   // samples; any agreeing sample restarts the count.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic            s1;
      logic            s2;
      logic            lvl;
      logic [DB_W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
         end else begin
            s1 <= raw[i];
            s2 <= s1;
            if (s2 != lvl) begin
               if (cnt == DB_LAST) begin
                  lvl <= s2;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + DB_W'(1);
               end
            end else begin
               cnt <= '0;
            end
         end
      end

      assign level[i] = lvl;
   end

   assign up_level   = level[0];
   assign down_level = level[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= 2'b00;
      end else begin
         level_d <= level;
      end
   end

   logic rise_up;
   logic rise_down;

   assign rise_up   = level[0] & ~level_d[0];
   assign rise_down = level[1] & ~level_d[1];

   // ------------------------------------------------------------------------
   // Command FSM
   // ------------------------------------------------------------------------
   state_t          state;
   state_t          state_nx;
   logic [1:0]      select_nx;
   logic [RP_W-1:0] rpt_cnt;
   logic [RP_W-1:0] rpt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         select  <= SEL_IDLE;
         rpt_cnt <= '0;
      end else begin
         state   <= state_nx;
         select  <= select_nx;
         rpt_cnt <= rpt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      select_nx = SEL_IDLE;
      rpt_nx    = rpt_cnt;
      case (state)
         IDLE: begin
            // A rise with the other button already (or simultaneously) down
            // is ambiguous: issue nothing and wait for a full release.
            if ((rise_up && down_level) || (rise_down && up_level)) begin
               state_nx = LOCKOUT;
            end else if (rise_up) begin
               select_nx = SEL_UP;
               state_nx  = HOLD_UP;
               rpt_nx    = '0;
            end else if (rise_down) begin
               select_nx = SEL_DOWN;
               state_nx  = HOLD_DOWN;
               rpt_nx    = '0;
            end
         end
         HOLD_UP: begin
            if (down_level) begin
               state_nx = LOCKOUT;
            end else if (!up_level) begin
               state_nx = IDLE;
            end else if (rpt_cnt == RP_LAST) begin
               // With repeat disabled the counter parks at its last value.
               if (REPEAT_EN != 0) begin
                  select_nx = SEL_UP;
                  rpt_nx    = '0;
               end
            end else begin
               rpt_nx = rpt_cnt + RP_W'(1);
            end
         end
         HOLD_DOWN: begin
            if (up_level) begin
               state_nx = LOCKOUT;
            end else if (!down_level) begin
               state_nx = IDLE;
            end else if (rpt_cnt == RP_LAST) begin
               if (REPEAT_EN != 0) begin
                  select_nx = SEL_DOWN;
                  rpt_nx    = '0;
               end
            end else begin
               rpt_nx = rpt_cnt + RP_W'(1);
            end
         end
         LOCKOUT: begin
            if (!up_level && !down_level) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/octave_select_ctrl.md
# octave_select_ctrl

Debounces the raw octave-up and octave-down pushbuttons and turns them into the 2-bit `select` command consumed by the octave register stage. It emits single-cycle `select` pulses: 01 increases the octave, 10 decreases it, and 00 leaves it unchanged. Holding a button optionally produces auto-repeat pulses. Simultaneous or conflicting presses are suppressed. The block sits between the board button pins and the octave stage, in the same clock domain as that stage.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a button level change. Minimum value is 2.
- `REPEAT_CYCLES`, default 50000000: spacing, in cycles, between auto-repeat pulses while a button is held. Minimum value is 2.
- `REPEAT_EN`, default 1: set to 1 to enable auto-repeat, 0 to disable it.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `btn_up`  in  1  raw octave-up button; active-high; asynchronous to `clk`; may bounce.
- `btn_down`  in  1  raw octave-down button; same properties as `btn_up`.
- `select`  out  2  command to the octave stage: 00 idle, 01 up, 10 down. Never 11. Registered.
- `up_level`  out  1  debounced level of `btn_up`. Registered.
- `down_level`  out  1  debounced level of `btn_down`. Registered.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, giving `s2_up` and `s2_down`.
- **Debouncer (one per button):** a counter `cnt`, sized with $clog2(DEBOUNCE_CYCLES).
  - On each edge where `s2 != level`: `cnt <= cnt+1`.
  - If that edge sees `cnt == DEBOUNCE_CYCLES-1`: `level <= s2` and `cnt <= 0`.
  - On any edge where `s2 == level`: `cnt <= 0`.
- **Edge detect:** `level_d` registers each level. A rise is `level & ~level_d`.
- **FSM states:** IDLE, HOLD_UP, HOLD_DOWN, LOCKOUT.
- **IDLE:**
  - Both rises in the same cycle, or a rise while the other level is already high: go to LOCKOUT, `select` stays 00.
  - Up rise alone: `select <= 01`, go to HOLD_UP, `rpt_cnt <= 0`.
  - Down rise alone: `select <= 10`, go to HOLD_DOWN, `rpt_cnt <= 0`.
- **HOLD_UP (HOLD_DOWN is symmetric, with 10):**
  - `down_level` high: go to LOCKOUT, no pulse. This takes priority over the release and repeat rules.
  - `up_level` low: go to IDLE.
  - Otherwise `rpt_cnt` increments each cycle. When `rpt_cnt == REPEAT_CYCLES-1`:
    - with REPEAT_EN=1: `select <= 01` and `rpt_cnt <= 0`.
    - with REPEAT_EN=0: the counter saturates and no pulse is issued.
- **LOCKOUT:** `select` is 00. Go to IDLE only when both debounced levels are low.
- **`select` default:** 00 in every cycle not named above, so each pulse lasts exactly one cycle.
- **Reset:** all flops clear asynchronously, including the synchronizers.
  - Outputs are `select`=00, `up_level`=0, `down_level`=0, state IDLE.
  - If a button is still held when `rst_n` deasserts, it is re-debounced and yields one fresh pulse.

## Timing
- **Press latency:** the raw change is first sampled at edge E0. `level` updates at edge E0+1+DEBOUNCE_CYCLES. `select` is registered high at edge E0+2+DEBOUNCE_CYCLES and low again at the next edge.
- **Release latency:** identical path. The FSM leaves HOLD at edge E0+2+DEBOUNCE_CYCLES.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `level`.
- **Repeat spacing:** pulses repeat every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after the initial pulse.
- **Pulse width:** `select` is never high on two consecutive cycles. This holds because REPEAT_CYCLES ≥ 2.
- **Reset deassertion:** treated as synchronous to `clk` by the system. The first sampling edge is the first edge after deassertion.

## Test plan
Parameters for all scenarios are DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=16 unless noted.
- **Clean press:** `btn_up` rises before edge 0 and is held 12 cycles, then released -> `select`=01 exactly in the cycle after edge 6, otherwise 00. `up_level` is high from edge 5 to edge 17.
- **Bounce:** `btn_down` toggles every 2 cycles for 20 cycles, then stays high -> no pulse during bouncing. A single `select`=10 appears 6 edges after the final stable sampling edge.
- **Auto-repeat:** `btn_up` is held 60 cycles -> 01 pulses at T, T+16, T+32 and T+48. Rerun with REPEAT_EN=0 -> only the pulse at T.
- **Simultaneous press and recovery:** both buttons rise on the same edge -> `select` stays 00. Release both, then press `btn_down` alone -> one 10 pulse.
- **Conflict during hold:** `btn_up` is held and pulses once, then `btn_down` is pressed -> no 10 pulse and no further 01 repeats. `select` stays 00 until both are released.
- **Reset mid-hold:** `rst_n` is driven low while in HOLD_UP -> `select`, `up_level` and `down_level` go to 0 immediately. After `rst_n` rises with `btn_up` still high -> one 01 pulse 6 edges later.
